// File: rtl/mux41_pkg.sv
// Shared definitions for the 4-to-1 conditional-operator selector.
// Contents: select-code encodings and the default operand width.
package mux41_pkg;

  localparam int MUX_W = 4;

  typedef enum logic [1:0] {
    SEL_A = 2'd0,
    SEL_B = 2'd1,
    SEL_C = 2'd2,
    SEL_D = 2'd3
  } sel_e;

endpackage

// File: rtl/mux41_conop_if.sv
// Bus bundle for mux41_conop.
// master : drives en, sel, a..d; observes y_comb, y, y_valid, sel_q.
// slave  : the selector itself.
interface mux41_conop_if #(
  parameter int WIDTH = mux41_pkg::MUX_W
);
  logic             en;
  logic [1:0]       sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] y_comb;
  logic [WIDTH-1:0] y;
  logic             y_valid;
  logic [1:0]       sel_q;

  modport master (
    output en, sel, a, b, c, d,
    input  y_comb, y, y_valid, sel_q
  );

  modport slave (
    input  en, sel, a, b, c, d,
    output y_comb, y, y_valid, sel_q
  );
endinterface

// File: rtl/mux41_core.sv
// Purely combinational 4-to-1 selector written as a nested conditional.
// Ports: sel (2-bit code), a/b/c/d (WIDTH-bit sources), y (selected value).
// An X/Z select resolves bitwise where the candidates agree, X elsewhere.
module mux41_core
  import mux41_pkg::*;
#(
  parameter int WIDTH = MUX_W
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] y
);

  assign y = (sel == SEL_A) ? a :
             (sel == SEL_B) ? b :
             (sel == SEL_C) ? c : d;

endmodule

// File: rtl/mux41_conop.sv
// 4-to-1 operand selector with a combinational and an optional registered
// result.
// Ports: clk, rst_n (async active-low), bus (slave modport: en, sel, a..d in;
// y_comb, y, y_valid, sel_q out).
// REG_OUT=1: y/sel_q capture on en, y_valid pulses one cycle per capture.
// REG_OUT=0: y/y_valid/sel_q are straight combinational copies.
module mux41_conop
  import mux41_pkg::*;
#(
  parameter int WIDTH   = MUX_W,
  parameter bit REG_OUT = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  mux41_conop_if.slave  bus
);

  mux41_core #(.WIDTH(WIDTH)) u_core (
    .sel (bus.sel),
    .a   (bus.a),
    .b   (bus.b),
    .c   (bus.c),
    .d   (bus.d),
    .y   (bus.y_comb)
  );

  generate
    if (REG_OUT) begin : g_reg
      logic [WIDTH-1:0] y_r;
      logic             valid_r;
      logic [1:0]       sel_r;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          y_r     <= '0;
          valid_r <= 1'b0;
          sel_r   <= 2'd0;
        end else if (bus.en) begin
          y_r     <= bus.y_comb;
          valid_r <= 1'b1;
          sel_r   <= bus.sel;
        end else begin
          valid_r <= 1'b0;
        end
      end

      assign bus.y       = y_r;
      assign bus.y_valid = valid_r;
      assign bus.sel_q   = sel_r;
    end else begin : g_comb
      // clk/rst_n have no load in this build; folded here to keep them
      // visibly intentional.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;

      assign bus.y       = bus.y_comb;
      assign bus.y_valid = bus.en;
      assign bus.sel_q   = bus.sel;
    end
  endgenerate

endmodule

// File: tb/tb_mux41_conop.sv
module tb_mux41_conop;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_mis;

  mux41_conop_if #(.WIDTH(4)) bus4 ();
  mux41_conop_if #(.WIDTH(8)) bus8 ();
  mux41_conop_if #(.WIDTH(4)) busc ();

  mux41_conop #(.WIDTH(4), .REG_OUT(1'b1)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  mux41_conop #(.WIDTH(8), .REG_OUT(1'b1)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  mux41_conop #(.WIDTH(4), .REG_OUT(1'b0)) dutc (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] sweep_exp [4];
    n_cmp = 0;
    n_mis = 0;
    sweep_exp[0] = 4'h1;
    sweep_exp[1] = 4'h2;
    sweep_exp[2] = 4'h4;
    sweep_exp[3] = 4'h8;

    rst_n    = 1'b0;
    bus4.en  = 1'b0; bus4.sel = 2'd0;
    bus4.a   = '0;   bus4.b   = '0; bus4.c = '0; bus4.d = '0;
    bus8.en  = 1'b0; bus8.sel = 2'd0;
    bus8.a   = '0;   bus8.b   = '0; bus8.c = '0; bus8.d = '0;
    busc.en  = 1'b0; busc.sel = 2'd0;
    busc.a   = '0;   busc.b   = '0; busc.c = '0; busc.d = '0;

    // reset / idle
    #100;
    rst_n = 1'b1;
    #1;
    check("idle_y",       {4'h0, bus4.y},      8'h00);
    check("idle_y_valid", {7'h0, bus4.y_valid}, 8'h00);
    check("idle_y_comb",  {4'h0, bus4.y_comb}, 8'h00);
    check("idle_sel_q",   {6'h0, bus4.sel_q},  8'h00);
    check("idle_y8",      bus8.y,              8'h00);

    // full select sweep
    bus4.a = 4'h1; bus4.b = 4'h2; bus4.c = 4'h4; bus4.d = 4'h8;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus4.sel = 2'(i);
      bus4.en  = 1'b1;
      #1;
      check($sformatf("sweep_y_comb_%0d", i), {4'h0, bus4.y_comb}, {4'h0, sweep_exp[i]});
      @(posedge clk);
      #1;
      check($sformatf("sweep_y_%0d", i),       {4'h0, bus4.y},      {4'h0, sweep_exp[i]});
      check($sformatf("sweep_valid_%0d", i),   {7'h0, bus4.y_valid}, 8'h01);
      check($sformatf("sweep_sel_q_%0d", i),   {6'h0, bus4.sel_q},  8'(i));
    end

    // hold
    @(negedge clk);
    bus4.sel = 2'd2; bus4.c = 4'hA; bus4.en = 1'b1;
    @(posedge clk); #1;
    check("hold_cap_y",     {4'h0, bus4.y},      8'h0A);
    check("hold_cap_sel_q", {6'h0, bus4.sel_q},  8'h02);
    @(negedge clk);
    bus4.en = 1'b0; bus4.c = 4'h5; bus4.sel = 2'd3;
    #1;
    check("hold_y_comb_d",  {4'h0, bus4.y_comb}, 8'h08);
    check("hold_y_between", {4'h0, bus4.y},      8'h0A);
    @(posedge clk); #1;
    check("hold_y",         {4'h0, bus4.y},      8'h0A);
    check("hold_valid",     {7'h0, bus4.y_valid}, 8'h00);
    check("hold_sel_q",     {6'h0, bus4.sel_q},  8'h02);
    @(posedge clk); #1;
    check("hold_y_2",       {4'h0, bus4.y},      8'h0A);

    // async reset mid-operation
    @(negedge clk);
    bus4.sel = 2'd0; bus4.a = 4'hF; bus4.en = 1'b1;
    @(posedge clk); #1;
    check("arst_pre_y",     {4'h0, bus4.y},      8'h0F);
    check("arst_pre_valid", {7'h0, bus4.y_valid}, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_y",         {4'h0, bus4.y},      8'h00);
    check("arst_valid",     {7'h0, bus4.y_valid}, 8'h00);
    check("arst_sel_q",     {6'h0, bus4.sel_q},  8'h00);
    check("arst_y_comb",    {4'h0, bus4.y_comb}, 8'h0F);
    @(posedge clk); #1;
    check("arst_held_y",    {4'h0, bus4.y},      8'h00);
    @(negedge clk);
    rst_n   = 1'b1;
    bus4.en = 1'b0;
    @(posedge clk); #1;
    check("rel_no_valid",   {7'h0, bus4.y_valid}, 8'h00);
    check("rel_y",          {4'h0, bus4.y},      8'h00);
    @(negedge clk);
    bus4.sel = 2'd1; bus4.b = 4'h2; bus4.en = 1'b1;
    @(posedge clk); #1;
    check("rel_cap_y",      {4'h0, bus4.y},      8'h02);
    check("rel_cap_valid",  {7'h0, bus4.y_valid}, 8'h01);
    check("rel_cap_sel_q",  {6'h0, bus4.sel_q},  8'h01);
    @(negedge clk);
    bus4.en = 1'b0;

    // 8-bit boundary: alternate FF/00
    bus8.a = 8'hFF; bus8.b = 8'h5A; bus8.c = 8'hA5; bus8.d = 8'h00;
    bus8.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus8.sel = (i % 2 == 0) ? 2'd0 : 2'd3;
      @(posedge clk); #1;
      check($sformatf("w8_y_%0d", i),     bus8.y,              (i % 2 == 0) ? 8'hFF : 8'h00);
      check($sformatf("w8_valid_%0d", i), {7'h0, bus8.y_valid}, 8'h01);
    end
    @(negedge clk);
    bus8.en = 1'b0;

    // combinational build
    busc.sel = 2'd1; busc.b = 4'h6; busc.a = 4'h3; busc.en = 1'b1;
    #1;
    check("comb_y",       {4'h0, busc.y},      8'h06);
    check("comb_y_comb",  {4'h0, busc.y_comb}, 8'h06);
    check("comb_valid",   {7'h0, busc.y_valid}, 8'h01);
    check("comb_sel_q",   {6'h0, busc.sel_q},  8'h01);
    busc.en = 1'b0; busc.sel = 2'd0;
    #1;
    check("comb_y_a",     {4'h0, busc.y},      8'h03);
    check("comb_valid_0", {7'h0, busc.y_valid}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mux41_conop.md
Name: mux41_conop

Overview:
- 4-to-1 selector of WIDTH-bit operands, built with a nested conditional operator.
- Provides a combinational result and a registered, qualified result.
- Sits in the datapath wherever one of four same-width sources is picked by a 2-bit code, for example as an operand or result select.
- The bench starts from all-zero inputs, so zero in and zero out is the idle state.

Parameters:
- WIDTH, 4, bit width of a, b, c, d, y and y_comb.
- REG_OUT, 1, 1 = y is registered with 1-cycle latency; 0 = y equals y_comb and y_valid equals en, both combinational.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  capture enable / input-valid qualifier.
- sel  input  2  source select: 0=a, 1=b, 2=c, 3=d.
- a  input  WIDTH  source 0.
- b  input  WIDTH  source 1.
- c  input  WIDTH  source 2.
- d  input  WIDTH  source 3.
- y_comb  output  WIDTH  combinational selected value.
- y  output  WIDTH  selected value; registered when REG_OUT=1.
- y_valid  output  1  y holds a freshly captured value.
- sel_q  output  2  sel captured with the last accepted sample (debug/tracking).

Behaviour:
- Combinational path:
  - y_comb = (sel==2'd0) ? a : (sel==2'd1) ? b : (sel==2'd2) ? c : d.
  - Zero latency; no width extension or truncation.
- sel with X/Z in simulation:
  - Conditional-operator semantics apply: bits where the candidate sources agree resolve; differing bits go X.
  - Synthesis treats this case as don't-care.
- Registered path (REG_OUT=1):
  - On rst_n falling: y=0, y_valid=0, sel_q=0 immediately, independent of clk.
  - While rst_n=0, all registers hold 0; the first capture is the first rising clk edge with rst_n=1.
  - At rising clk with en=1: y <= y_comb, sel_q <= sel, y_valid <= 1.
  - At rising clk with en=0: y and sel_q hold; y_valid <= 0.
  - Latency from en/sel/data to y is exactly 1 cycle; y_valid is a one-cycle pulse per accepted sample.
  - Back-to-back en gives a new y every cycle.
- Data changes between edges do not disturb y; y_comb follows inputs immediately.
- Reset asserted mid-stream: pending capture is discarded and outputs clear asynchronously.
- Reset released: no spurious y_valid until en=1 is sampled.
- REG_OUT=0:
  - y = y_comb, y_valid = en, sel_q = sel.
  - clk and rst_n are unused; no registers are inferred.
- y_comb is never affected by reset.

Decomposition:
- Shared package mux41_pkg:
  - Select encodings SEL_A=2'd0, SEL_B=2'd1, SEL_C=2'd2, SEL_D=2'd3.
  - Default width constant MUX_W=4.
- One natural sub-module, mux41_core: purely combinational conditional-operator selector, parameterized by WIDTH.
- Top level adds the capture register, valid flag and REG_OUT generate branch.

Test Plan:
- Reset/idle: rst_n=0, all inputs 0, then release at 100 ns -> y=0, y_valid=0, y_comb=0, sel_q=0.
- Full select sweep: a=4'h1, b=4'h2, c=4'h4, d=4'h8, en=1, sel=0,1,2,3 on successive cycles:
  - y_comb = 1, 2, 4, 8 immediately.
  - y = 1, 2, 4, 8 one cycle later with y_valid=1 each cycle; sel_q tracks.
- Hold: capture sel=2 with c=4'hA, then en=0 while c changes to 4'h5 and sel changes to 3:
  - y stays 4'hA, y_valid=0.
  - y_comb follows, giving d.
- Async reset mid-operation: y=4'hF, assert rst_n=0 between clock edges -> y=0, y_valid=0 without a clock edge; the first en=1 after release captures correctly.
- Width/boundary: WIDTH=8, a=8'hFF, d=8'h00, toggle sel 0<->3 every cycle with en=1 -> y alternates FF/00 with no bit loss.
- REG_OUT=0 build: sel=1, b=4'h6, en=1 -> y=4'h6 and y_valid=1 in the same delta, with no clock required.
